// File: rtl/risc16_pkg.sv
// risc16_pkg -- definitions shared across the RiSC16 codebase.
//   WORD_W         instruction width (fixed at 16 for RiSC16)
//   REG_FILE_SIZE  number of architectural registers
//   LEN_HI..ERR    instruction-memory loader state encoding
//   loader_state_e enum built on that encoding
//   accepts_bytes  which loader states may take a stream byte
package risc16_pkg;

  localparam int WORD_W        = 16;
  localparam int REG_FILE_SIZE = 8;

  // Loader state encoding.
  localparam logic [2:0] LEN_HI  = 3'd0;
  localparam logic [2:0] LEN_LO  = 3'd1;
  localparam logic [2:0] DATA_HI = 3'd2;
  localparam logic [2:0] DATA_LO = 3'd3;
  localparam logic [2:0] CKSUM   = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  typedef enum logic [2:0] {
    ST_LEN_HI  = LEN_HI,
    ST_LEN_LO  = LEN_LO,
    ST_DATA_HI = DATA_HI,
    ST_DATA_LO = DATA_LO,
    ST_CKSUM   = CKSUM,
    ST_DONE    = DONE,
    ST_ERR     = ERR
  } loader_state_e;

  // A state takes bytes unless the frame has finished (good or bad).
  function automatic logic accepts_bytes(input loader_state_e s);
    logic r;
    case (s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CKSUM: r = 1'b1;
      ST_DONE, ST_ERR:                                        r = 1'b0;
      default:                                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/risc16_imem_loader_if.sv
// risc16_imem_loader_if -- byte-stream handshake plus instruction-memory
// write port of the boot loader.
//   in_valid/in_data/in_ready  byte stream (source is master)
//   mem_we/mem_addr/mem_wdata  word writes toward the instruction memory
// Modports: master = stream source / memory side, slave = loader.
interface risc16_imem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/risc16_imem_loader.sv
// risc16_imem_loader -- boot-time writer for the RiSC16 instruction memory.
// Receives a frame {N_hi, N_lo, N x (hi, lo) [, cksum]} over a byte
// handshake, writes each assembled word, holds the core in reset while
// loading and releases it once the image is complete.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   reload     synchronous one-cycle pulse, restarts loading
//   bus        risc16_imem_loader_if.slave (byte stream + memory write port)
//   cpu_reset  active-high core reset, low only in DONE
//   done       image loaded
//   error      frame rejected
// Build option: define LOADER_CKSUM_EN to require a trailing XOR checksum
// byte over the payload; without it the last data byte completes the frame.
module risc16_imem_loader
  import risc16_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = risc16_pkg::WORD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reload,
  risc16_imem_loader_if.slave  bus,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  // Where a frame goes once all payload words have been received.
`ifdef LOADER_CKSUM_EN
  localparam loader_state_e ST_AFTER_DATA = ST_CKSUM;
`else
  localparam loader_state_e ST_AFTER_DATA = ST_DONE;
`endif

  // Frame length limit is the memory capacity; 17 bits holds 2^16.
  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  loader_state_e     state_r, state_s;
  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [WORD_W-1:0] mem_wdata_r;
  logic              cpu_reset_r, done_r, error_r;
  logic [15:0]       n_r;
  logic [ADDR_W-1:0] idx_r;
  logic [7:0]        hi_r;
  logic              xfer_s;
  logic [16:0]       len_s;
  logic              last_word_s;
`ifdef LOADER_CKSUM_EN
  logic [7:0]        acc_r;
`endif

  assign xfer_s = bus.in_valid & in_ready_r;
  // Length as it becomes complete on the LEN_LO transfer.
  assign len_s  = {1'b0, n_r[15:8], bus.in_data};
  // The word being completed is word N-1.
  assign last_word_s = (({{(17-ADDR_W){1'b0}}, idx_r} + 17'd1) == {1'b0, n_r});

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LEN_HI;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; reload overrides any byte offered in the same cycle.
  always_comb begin
    state_s = state_r;
    if (reload) begin
      state_s = ST_LEN_HI;
    end else if (xfer_s) begin
      case (state_r)
        ST_LEN_HI:  state_s = ST_LEN_LO;
        ST_LEN_LO: begin
          if (len_s > CAPACITY) begin
            state_s = ST_ERR;
          end else if (len_s == 17'd0) begin
            state_s = ST_AFTER_DATA;
          end else begin
            state_s = ST_DATA_HI;
          end
        end
        ST_DATA_HI: state_s = ST_DATA_LO;
        ST_DATA_LO: begin
          if (last_word_s) begin
            state_s = ST_AFTER_DATA;
          end else begin
            state_s = ST_DATA_HI;
          end
        end
`ifdef LOADER_CKSUM_EN
        ST_CKSUM: begin
          if (bus.in_data == acc_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ERR;
          end
        end
`endif
        default:    state_s = state_r;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Status outputs follow the next state so cpu_reset drops together with
  // the final write strobe, never before it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_r  <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      in_ready_r  <= accepts_bytes(state_s);
      cpu_reset_r <= (state_s != ST_DONE);
      done_r      <= (state_s == ST_DONE);
      error_r     <= (state_s == ST_ERR);
    end
  end

  // Datapath: length capture, word assembly, memory write strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      n_r         <= 16'd0;
      idx_r       <= '0;
      hi_r        <= 8'd0;
    end else begin
      mem_we_r <= 1'b0;
      if (reload) begin
        idx_r <= '0;
      end else if (xfer_s) begin
        case (state_r)
          ST_LEN_HI:  n_r[15:8] <= bus.in_data;
          ST_LEN_LO:  n_r[7:0]  <= bus.in_data;
          ST_DATA_HI: hi_r      <= bus.in_data;
          ST_DATA_LO: begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= idx_r;
            mem_wdata_r <= {hi_r, bus.in_data};
            idx_r       <= idx_r + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CKSUM_EN
  // Running XOR over payload bytes only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= 8'd0;
    end else if (reload) begin
      acc_r <= 8'd0;
    end else if (xfer_s && (state_r == ST_DATA_HI || state_r == ST_DATA_LO)) begin
      acc_r <= acc_r ^ bus.in_data;
    end
  end
`endif

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign cpu_reset     = cpu_reset_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: doc/risc16_imem_loader.md
Name: risc16_imem_loader

Overview:
- Boot-time writer for the RiSC16 non-pipelined core's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes each word to the instruction-memory write port while holding the core in reset.
- Releases the core (active-high core reset) once the whole image is loaded.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; capacity 2^ADDR_W words.
- WORD_W, 16, instruction width; fixed at 16 for RiSC16; any other value is illegal.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- reload  in  1  synchronous one-cycle pulse; restarts loading.
- mem_we  out  1  instruction-memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  WORD_W  instruction word.
- cpu_reset  out  1  active-high reset to the core; asserted while loading.
- done  out  1  image loaded successfully.
- error  out  1  frame rejected.

Behaviour:
- Reset (reset=0, async): state=LEN_HI, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, word count=0, word index=0.
- in_ready is a registered output:
  - 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CKSUM.
  - 0 in DONE and ERR.
  - 0 for the first cycle after reset release.
- A byte transfers only on a cycle with in_valid=1 and in_ready=1.
- Frame format: N_hi, N_lo (16-bit big-endian word count), then N words sent high byte first, then an optional checksum byte.
- FSM:
  - LEN_HI -> LEN_LO on a transfer; latch N[15:8].
  - LEN_LO on a transfer:
    - If N > 2^ADDR_W -> ERR.
    - Else if N=0 -> CKSUM when the checksum feature is in, otherwise DONE.
    - Else -> DATA_HI.
  - DATA_HI -> DATA_LO on a transfer; latch the high byte.
  - DATA_LO on a transfer:
    - The cycle after: mem_we=1 for exactly 1 cycle, mem_addr=word index, mem_wdata={hi,lo}.
    - Word index increments after the write.
    - If this was word N-1 -> CKSUM (feature in) or DONE; otherwise -> DATA_HI.
  - CKSUM: see Optional Feature.
  - DONE: done=1, cpu_reset=0, both registered. cpu_reset falls the cycle after entering DONE, which is the same cycle as the last mem_we. The core therefore leaves reset no earlier than the final write.
  - ERR: error=1, cpu_reset stays 1.
- reload=1 in any state: next state=LEN_HI; cpu_reset=1, done=0, error=0, word index=0. Memory contents are left unchanged.
  - reload has priority over a simultaneous byte transfer; that byte is dropped.
- Word index wraps only at 2^ADDR_W. The length check guarantees wrap never occurs on a legal frame.
- Back-to-back bytes (in_valid held high) must sustain 1 byte per cycle with no bubbles.
- Async reset mid-frame: all state clears immediately; partial words are lost.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined:
  - The CKSUM state is present; a running XOR accumulates every payload byte (not the length bytes).
  - The next transferred byte is compared with the accumulator: equal -> DONE, unequal -> ERR.
  - The accumulator clears on reset and on reload.
- Undefined:
  - No CKSUM state and no accumulator.
  - The last DATA_LO transfer (or LEN_LO with N=0) goes directly to DONE.

Decomposition:
- Shared package risc16_pkg holds:
  - WORD_W=16.
  - The loader state encoding as localparams: LEN_HI, LEN_LO, DATA_HI, DATA_LO, CKSUM, DONE, ERR.
  - The existing REG_FILE_SIZE definition.
- No sub-module is natural. The block is one FSM plus datapath registers; the XOR accumulator is inline and guarded by the macro.

Test Plan:
- Stream 00 02 12 34 AB CD with continuous valid -> mem_we pulses writing addr0=0x1234 and addr1=0xABCD on consecutive-pair cycles; done=1; cpu_reset falls the cycle after the second byte of word 1 is accepted.
- Same image with in_valid toggled every other cycle -> identical writes; in_ready stays 1; no spurious mem_we.
- ADDR_W=4, stream 00 11 -> error=1, in_ready=0, cpu_reset=1, mem_we never asserted.
- With LOADER_CKSUM_EN: stream 00 01 12 34 26 -> done=1. Stream 00 01 12 34 27 -> error=1, cpu_reset=1. Then pulse reload and send 00 00 00 -> done=1.
- Pulse reload after 00 03 12 34 (mid-frame), then send 00 01 BE EF -> addr0=0xBEEF, done=1, no write to addr1.
- Assert reset low during DATA_LO -> outputs return to reset values asynchronously; the next frame 00 01 00 01 writes addr0=0x0001.
